// File: rtl/md_sched.sv
// Multiply/divide sequencer for the E stage. Owns HI/LO, computes the result
// in the start cycle, holds it for a fixed latency, then commits to HI/LO.
// A flush squashes both the incoming operation and any operation in flight.
module md_sched #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        no_commit_q, no_commit_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Arithmetic datapath, evaluated only in the start cycle.
  logic signed [63:0] a_sx, b_sx;
  logic [63:0] mul_s, mul_u;
  logic [31:0] b_nz, a_mag, b_mag, q_mag, r_mag;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  // Products, and divide via magnitudes so INT_MIN / -1 wraps naturally.
  always_comb begin
    a_sx  = {{32{A[31]}}, A};
    b_sx  = {{32{B[31]}}, B};
    mul_s = a_sx * b_sx;
    mul_u = {32'd0, A} * {32'd0, B};
    // Divisor forced non-zero so the dividers never see zero; result is discarded anyway.
    b_nz  = (B == 32'd0) ? 32'd1 : B;
    quo_u = A / b_nz;
    rem_u = A % b_nz;
    a_mag = A[31] ? (~A + 32'd1) : A;
    b_mag = b_nz[31] ? (~b_nz + 32'd1) : b_nz;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    quo_s = (A[31] ^ b_nz[31]) ? (~q_mag + 32'd1) : q_mag;
    rem_s = A[31] ? (~r_mag + 32'd1) : r_mag;
  end

  // Busy covers the start cycle combinationally plus every RUN cycle.
  always_comb begin
    busy = (start & ~md_op[2] & ~flush) | (state_q == StRun);
  end

  // Next-state: accept ops in IDLE, count down in RUN, commit on the last cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    no_commit_d = no_commit_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          unique case (md_op)
            3'd0: begin
              {res_hi_d, res_lo_d} = mul_s;
              cnt_d       = 4'(MULT_CYC);
              no_commit_d = 1'b0;
              state_d     = StRun;
            end
            3'd1: begin
              {res_hi_d, res_lo_d} = mul_u;
              cnt_d       = 4'(MULT_CYC);
              no_commit_d = 1'b0;
              state_d     = StRun;
            end
            3'd2: begin
              res_hi_d    = rem_s;
              res_lo_d    = quo_s;
              cnt_d       = 4'(DIV_CYC);
              no_commit_d = (B == 32'd0);
              state_d     = StRun;
            end
            3'd3: begin
              res_hi_d    = rem_u;
              res_lo_d    = quo_u;
              cnt_d       = 4'(DIV_CYC);
              no_commit_d = (B == 32'd0);
              state_d     = StRun;
            end
            3'd4:    hi_d = A;
            3'd5:    lo_d = A;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = StIdle;
            if (!no_commit_q) begin
              hi_d = res_hi_q;
              lo_d = res_lo_q;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and architectural register update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      res_hi_q    <= 32'd0;
      res_lo_q    <= 32'd0;
      no_commit_q <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      no_commit_q <= no_commit_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: expected HI/LO pushed to a scoreboard at issue,
// popped and compared once the operation has finished.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_errs = 0;
  logic [63:0] sb_q[$];
  logic [63:0] cur_hilo = 64'd0;

  md_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [63:0] exp;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      check(tag, {HI, LO}, exp);
      cur_hilo = exp;
    end
  endtask

  // Independent reference: 64-bit arithmetic avoids any 32-bit overflow corner.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd0: model = sa * sb;
      3'd1: model = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) model = cur;
        else begin
          q = sa / sb;
          r = sa % sb;
          model = {r[31:0], q[31:0]};
        end
      end
      3'd3:    model = (b == 32'd0) ? cur : {a % b, a / b};
      3'd4:    model = {a, cur[31:0]};
      3'd5:    model = {cur[63:32], a};
      default: model = cur;
    endcase
  endfunction

  // Issue one op, count busy cycles (bounded), confirm HI/LO hold until commit.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy, input logic [63:0] exp);
    int cycles;
    bit held;
    logic [63:0] pre;
    sb_q.push_back(exp);
    pre = {HI, LO};
    held = 1'b1;
    cycles = 0;
    @(posedge clk); #1;
    start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk);
    while (busy && cycles < 40) begin
      cycles++;
      if ({HI, LO} !== pre) held = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
    end
    if (start) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
    end
    check({tag, "_busy_cyc"}, 64'(cycles), 64'(exp_busy));
    if (exp_busy > 0) check({tag, "_hold"}, 64'(held), 64'd1);
    sb_check({tag, "_hilo"});
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] pre;

    // Reset state while held in reset.
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    #10 reset = 1'b1;

    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 6, {32'h00000001, 32'hFFFFFFFE});
    repeat (3) @(negedge clk);
    check("multu_stable", {HI, LO}, {32'h00000001, 32'hFFFFFFFE});

    run_op("mult", 3'd0, 32'hFFFFFFFD, 32'd7, 6, {32'hFFFFFFFF, 32'hFFFFFFEB});
    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 11, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("divu0", 3'd3, 32'd7, 32'd0, 11, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 11, {32'h00000000, 32'h80000000});
    run_op("rsvd", 3'd6, 32'h55555555, 32'd3, 0, {32'h00000000, 32'h80000000});

    // mthi then mtlo on consecutive cycles.
    sb_q.push_back({32'h12345678, cur_hilo[31:0]});
    sb_q.push_back({32'h12345678, 32'h9ABCDEF0});
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd4; A = 32'h12345678;
    @(negedge clk);
    check("mthi_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    md_op = 3'd5; A = 32'h9ABCDEF0;
    @(negedge clk);
    check("mtlo_busy", 64'(busy), 64'd0);
    sb_check("mthi_hilo");
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    sb_check("mtlo_hilo");

    // Flush on RUN cycle 3 of a mult.
    pre = {HI, LO};
    sb_q.push_back(pre);
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd0; A = 32'd5; B = 32'd6;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk);
    check("flush_run3_busy", 64'(busy), 64'd1);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_busy_drop", 64'(busy), 64'd0);
    repeat (8) @(negedge clk);
    sb_check("flush_hilo");

    // Start and flush together: ignored, including mthi.
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back({HI, LO});
      @(posedge clk); #1;
      start = 1'b1; flush = 1'b1; md_op = (k == 0) ? 3'd1 : 3'd4;
      A = 32'hDEADBEEF; B = 32'd9;
      @(negedge clk);
      check("sflush_busy0", 64'(busy), 64'd0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("sflush_busy1", 64'(busy), 64'd0);
      sb_check("sflush_hilo");
    end

    // Random ops against the reference model.
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom();
      rb = $urandom();
      if (i == 3) rb = 32'hFFFFFFFF;
      if (i == 5) ra = 32'h80000000;
      run_op("rand", rop, ra, rb, (rop < 3'd2) ? 6 : 11, model(rop, ra, rb, cur_hilo));
    end

    // Asynchronous reset in the middle of a divu.
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hilo", {HI, LO}, 64'd0);
    #2 reset = 1'b1;
    cur_hilo = 64'd0;
    run_op("post_rst", 3'd1, 32'd3, 32'd4, 6, {32'd0, 32'd12});

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide sequencer owning the HI/LO register pair in the E stage of the P7 pipeline.
- Accepts one operation per start pulse and holds the result internally for a fixed latency.
- Commits the result to HI/LO when the latency expires.
- Drives the busy signal that the stall unit uses to hold mthi/mtlo/mfhi/mflo/mult/div instructions in D.
- Supports abort on exception/interrupt flush so that a squashed E-stage operation never reaches HI/LO.

Parameters:
- MULT_CYC, 5, cycles busy stays high after the start cycle for mult/multu (range 1..15).
- DIV_CYC, 10, cycles busy stays high after the start cycle for div/divu (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  E-stage valid md/mt instruction this cycle (single-cycle pulse per instruction).
- md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no-op).
- A  in  32  forwarded rs value.
- B  in  32  forwarded rt value.
- flush  in  1  exception/interrupt request; aborts current and incoming operation.
- busy  out  1  start&(md_op<=3)&!flush OR state==RUN.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, cnt=0, HI=0, LO=0, res_hi=0, res_lo=0, pending op cleared. busy=0 while reset is asserted, given start=0.
- States:
  - IDLE: accepts start.
  - RUN: counting down; start is ignored (the stall unit guarantees none arrives; if one does, it has no effect on HI/LO or cnt).
- IDLE, start=1, flush=0:
  - mult: {res_hi,res_lo} = $signed(A)*$signed(B), 64-bit full product. cnt=MULT_CYC. Go to RUN.
  - multu: unsigned 64-bit product. cnt=MULT_CYC. Go to RUN.
  - div: res_lo = signed quotient, truncated toward zero. res_hi = signed remainder, sign of dividend A. cnt=DIV_CYC. Go to RUN.
  - divu: unsigned quotient in res_lo, unsigned remainder in res_hi. cnt=DIV_CYC. Go to RUN.
  - Divide by zero (B==0) for div/divu: enter RUN with full DIV_CYC latency but set the no-commit flag. HI/LO stay unchanged.
  - mthi: HI<=A at this edge. Stay in IDLE; busy is not asserted.
  - mtlo: LO<=A at this edge. Stay in IDLE; busy is not asserted.
  - Reserved op: no effect.
- RUN:
  - cnt decrements each cycle.
  - On the edge where cnt==1: HI<=res_hi, LO<=res_lo (unless no-commit), state<=IDLE.
  - busy is therefore high for exactly 1+N cycles: the start cycle plus N RUN cycles. HI/LO are visible the cycle after busy falls.
- Signed div overflow: 0x80000000 / -1 gives LO=0x80000000, HI=0. This is the natural 32-bit wrap; no trap.
- flush=1:
  - Start in the same cycle is ignored. mthi/mtlo are also suppressed.
  - If in RUN: return to IDLE at the next edge, cnt=0, HI/LO unchanged, busy low from the next cycle.
- Reset mid-RUN: immediate IDLE; HI/LO cleared to 0.
- HI/LO are driven directly from registers: no combinational path from A/B.

Test Plan:
- multu, A=0xFFFFFFFF, B=2 -> busy high for 6 cycles (start + 5). Then HI=0x00000001, LO=0xFFFFFFFE, both stable while idle.
- mult, A=-3 (0xFFFFFFFD), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB after MULT_CYC. HI/LO hold their old values on every cycle before the commit edge.
- div, A=-7, B=2 -> busy 11 cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu, A=7, B=0 -> busy 11 cycles, HI/LO unchanged.
- mthi A=0x12345678, then next cycle mtlo A=0x9ABCDEF0 -> HI=0x12345678 and LO=0x9ABCDEF0, each updated one edge after its start. busy never asserted.
- Flush:
  - mult start, then flush asserted on RUN cycle 3 -> busy drops the following cycle and HI/LO keep their pre-mult values.
  - start with flush=1 in the same cycle -> busy=0 and no state change.
- Drive reset low asynchronously mid-div (between clock edges) -> busy, HI and LO go to 0 immediately. After release, a new multu 3*4 gives LO=12, HI=0 after 5 cycles.
